cmd_saver: RTL and testbench

- Produces a TRS-80 /CMD byte stream from a RAM range, for upload to the HPS through the MiSTer ioctl upload path.
- It is the reverse direction of the CMD download loader. Its output must round-trip through that loader byte-exact.
- Sits between the system RAM read port and hps_io. It arbitrates RAM only while busy is high.

---
 rtl/cmd_pkg.sv | 35 +++
 rtl/cmd_saver.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cmd_saver.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Constants, state encoding and length helper for the TRS-80 /CMD format,
// shared by cmd_saver and the CMD download loader.
package cmd_pkg;

   localparam logic [7:0] CMD_TYPE_DATA = 8'h01;
   localparam logic [7:0] CMD_TYPE_EXEC = 8'h02;
   localparam logic [7:0] CMD_TYPE_NAME = 8'h05;
   localparam int         CMD_BLOCK_MAX = 256;

   typedef enum logic [3:0] {
      IDLE,
      D_TYPE,
      D_LEN,
      D_LSB,
      D_MSB,
      D_FETCH,
      D_DATA,
      X_TYPE,
      X_LEN,
      X_LSB,
      X_MSB,
`ifdef CMD_SAVER_LOADMOD_EN
      N_TYPE,
      N_LEN,
      N_BYTE,
`endif
      DONE
   } cmd_state_t;

   // The length byte counts the two address bytes, so a full 256-byte block encodes as 0x02.
   function automatic logic [7:0] cmd_len_enc(input logic [8:0] n);
      return 8'(n + 9'd2);
   endfunction

endpackage

// File: rtl/cmd_saver.sv
// cmd_saver: streams a RAM range out as a TRS-80 /CMD file over the ioctl upload path.
// Defining CMD_SAVER_LOADMOD_EN adds load_name and a leading type-05 name block.
module cmd_saver
   import cmd_pkg::*;
#(
   parameter int DATA   = 8,
   parameter int ADDR   = 16,
   parameter int INDEX  = 2,
   parameter int RD_LAT = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [ADDR-1:0] start_addr,
   input  logic [ADDR-1:0] end_addr,
   input  logic [ADDR-1:0] exec_addr,
`ifdef CMD_SAVER_LOADMOD_EN
   input  logic [63:0]     load_name,
`endif
   input  logic            ioctl_upload,
   input  logic [7:0]      ioctl_index,
   input  logic            ioctl_rd,
   output logic [DATA-1:0] ioctl_din,
   output logic            ioctl_wait,
   output logic            ram_rd,
   output logic [ADDR-1:0] ram_addr,
   input  logic [DATA-1:0] ram_data,
   output logic [23:0]     file_size,
   output logic            busy,
   output logic            done
);

   localparam int CW = ADDR + 1;
`ifdef CMD_SAVER_LOADMOD_EN
   localparam int NAME_BYTES = 10;
`else
   localparam int NAME_BYTES = 0;
`endif

   cmd_state_t      state_q, state_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [ADDR-1:0] exec_q, exec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [8:0]      blk_q, blk_d;
   logic [1:0]      lat_q, lat_d;
   logic [DATA-1:0] din_q, din_d;
   logic [23:0]     fsize_q, fsize_d;
   logic            wait_q, wait_d;
   logic            ram_rd_q, ram_rd_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            sel_q, sel_d;
`ifdef CMD_SAVER_LOADMOD_EN
   logic [63:0]     name_q, name_d;
   logic [2:0]      idx_q, idx_d;
`endif

   logic            sel, consume;
   logic [CW-1:0]   n_tot, n_blk, rem;
   logic [8:0]      first_len, next_len;

   assign sel       = ioctl_upload && (ioctl_index == 8'(INDEX));
   assign consume   = sel && ioctl_rd && !wait_q;
   assign n_tot     = (end_addr >= start_addr) ?
                      ({1'b0, end_addr} - {1'b0, start_addr} + CW'(1)) : '0;
   assign n_blk     = (n_tot + CW'(255)) >> 8;
   assign rem       = cnt_q - CW'(1);
   assign first_len = (n_tot > CW'(CMD_BLOCK_MAX)) ? 9'(CMD_BLOCK_MAX) : n_tot[8:0];
   assign next_len  = (rem > CW'(CMD_BLOCK_MAX)) ? 9'(CMD_BLOCK_MAX) : rem[8:0];

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      exec_d   = exec_q;
      cnt_d    = cnt_q;
      blk_d    = blk_q;
      lat_d    = lat_q;
      din_d    = din_q;
      fsize_d  = fsize_q;
      wait_d   = wait_q;
      ram_rd_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sel_d    = sel;
`ifdef CMD_SAVER_LOADMOD_EN
      name_d   = name_q;
      idx_d    = idx_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               addr_d  = start_addr;
               exec_d  = exec_addr;
               cnt_d   = n_tot;
               blk_d   = first_len;
               fsize_d = 24'(n_tot) + 24'({n_blk, 2'b00}) + 24'(4 + NAME_BYTES);
               busy_d  = 1'b1;
               wait_d  = 1'b0;
`ifdef CMD_SAVER_LOADMOD_EN
               name_d  = load_name;
               state_d = N_TYPE;
               din_d   = CMD_TYPE_NAME;
`else
               if (n_tot != '0) begin
                  state_d = D_TYPE;
                  din_d   = CMD_TYPE_DATA;
               end else begin
                  state_d = X_TYPE;
                  din_d   = CMD_TYPE_EXEC;
               end
`endif
            end
         end
`ifdef CMD_SAVER_LOADMOD_EN
         N_TYPE: if (consume) begin
            state_d = N_LEN;
            din_d   = 8'h08;
         end
         N_LEN: if (consume) begin
            state_d = N_BYTE;
            din_d   = name_q[63:56];
            idx_d   = 3'd0;
         end
         N_BYTE: if (consume) begin
            if (idx_q == 3'd7) begin
               state_d = (cnt_q != '0) ? D_TYPE : X_TYPE;
               din_d   = (cnt_q != '0) ? CMD_TYPE_DATA : CMD_TYPE_EXEC;
            end else begin
               idx_d  = idx_q + 3'd1;
               name_d = name_q << 8;
               din_d  = name_q[55:48];
            end
         end
`endif
         D_TYPE: if (consume) begin
            state_d = D_LEN;
            din_d   = cmd_len_enc(blk_q);
         end
         D_LEN: if (consume) begin
            state_d = D_LSB;
            din_d   = addr_q[7:0];
         end
         D_LSB: if (consume) begin
            state_d = D_MSB;
            din_d   = addr_q[15:8];
         end
         D_MSB: if (consume) begin
            state_d  = D_FETCH;
            wait_d   = 1'b1;
            ram_rd_d = 1'b1;
            lat_d    = 2'(RD_LAT);
         end
         // lat_q reaches zero in the cycle the RAM presents the read data.
         D_FETCH: begin
            if (lat_q == 2'd0) begin
               state_d = D_DATA;
               din_d   = ram_data;
               wait_d  = 1'b0;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         D_DATA: if (consume) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = rem;
            if (blk_q != 9'd1) begin
               blk_d    = blk_q - 9'd1;
               state_d  = D_FETCH;
               wait_d   = 1'b1;
               ram_rd_d = 1'b1;
               lat_d    = 2'(RD_LAT);
            end else if (rem != '0) begin
               blk_d   = next_len;
               state_d = D_TYPE;
               din_d   = CMD_TYPE_DATA;
            end else begin
               state_d = X_TYPE;
               din_d   = CMD_TYPE_EXEC;
            end
         end
         X_TYPE: if (consume) begin
            state_d = X_LEN;
            din_d   = 8'h02;
         end
         X_LEN: if (consume) begin
            state_d = X_LSB;
            din_d   = exec_q[7:0];
         end
         X_LSB: if (consume) begin
            state_d = X_MSB;
            din_d   = exec_q[15:8];
         end
         X_MSB: if (consume) begin
            state_d = DONE;
            wait_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Host dropped the upload for our index: abandon the stream without done.
      if (busy_q && sel_q && !ioctl_upload) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         wait_d   = 1'b1;
         ram_rd_d = 1'b0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         exec_q   <= '0;
         cnt_q    <= '0;
         blk_q    <= '0;
         lat_q    <= '0;
         din_q    <= '0;
         fsize_q  <= '0;
         wait_q   <= 1'b1;
         ram_rd_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sel_q    <= 1'b0;
`ifdef CMD_SAVER_LOADMOD_EN
         name_q   <= '0;
         idx_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         exec_q   <= exec_d;
         cnt_q    <= cnt_d;
         blk_q    <= blk_d;
         lat_q    <= lat_d;
         din_q    <= din_d;
         fsize_q  <= fsize_d;
         wait_q   <= wait_d;
         ram_rd_q <= ram_rd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sel_q    <= sel_d;
`ifdef CMD_SAVER_LOADMOD_EN
         name_q   <= name_d;
         idx_q    <= idx_d;
`endif
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign ram_rd     = ram_rd_q;
   assign ram_addr   = addr_q;
   assign file_size  = fsize_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_cmd_saver.sv
// Directed bench for cmd_saver: streams are pulled byte by byte through the ioctl
// handshake and compared against hand-derived /CMD layouts from a modelled RAM.
`timescale 1ns/1ps
module tb_cmd_saver;

   localparam int RD_LAT = 3;
`ifdef CMD_SAVER_LOADMOD_EN
   localparam int NAME_EXTRA = 10;
`else
   localparam int NAME_EXTRA = 0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] start_addr = '0;
   logic [15:0] end_addr = '0;
   logic [15:0] exec_addr = '0;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_rd = 1'b0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        ram_rd;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic [23:0] file_size;
   logic        busy;
   logic        done;
`ifdef CMD_SAVER_LOADMOD_EN
   logic [63:0] load_name = "PROG    ";
`endif

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int rd_cnt = 0;
   int rd_idle = 0;

   always #5 clock = ~clock;

   cmd_saver #(.DATA(8), .ADDR(16), .INDEX(2), .RD_LAT(RD_LAT)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .start_addr   (start_addr),
      .end_addr     (end_addr),
      .exec_addr    (exec_addr),
`ifdef CMD_SAVER_LOADMOD_EN
      .load_name    (load_name),
`endif
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .ram_rd       (ram_rd),
      .ram_addr     (ram_addr),
      .ram_data     (ram_data),
      .file_size    (file_size),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [7:0] ram_val(input logic [15:0] a);
      if (a == 16'h5200) return 8'hAA;
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // RAM with RD_LAT cycles from ram_rd to valid ram_data, data held for one cycle.
   logic [7:0] pipe [RD_LAT];
   always @(posedge clock) begin
      pipe[0] <= ram_rd ? ram_val(ram_addr) : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_data = pipe[RD_LAT-1];

   always @(posedge clock) begin
      if (done) done_cnt <= done_cnt + 1;
      if (ram_rd) rd_cnt <= rd_cnt + 1;
      if (ram_rd && !busy) rd_idle <= rd_idle + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic get_byte(input string tag, output logic [7:0] b, output int waits);
      waits = 0;
      while (ioctl_wait !== 1'b0 && waits < 50) begin
         @(negedge clock);
         waits++;
      end
      if (waits >= 50) check({tag, "_timeout"}, 32'(ioctl_wait), 32'd0);
      b = ioctl_din;
      ioctl_rd = 1'b1;
      @(negedge clock);
      ioctl_rd = 1'b0;
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      int w;
      get_byte(tag, b, w);
      check(tag, 32'(b), 32'(exp));
   endtask

   task automatic expect_data(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      int w;
      get_byte(tag, b, w);
      check(tag, 32'(b), 32'(exp));
      check({tag, "_lat"}, 32'(w), 32'(RD_LAT + 1));
   endtask

   task automatic do_start(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x);
      start_addr = s;
      end_addr   = e;
      exec_addr  = x;
      start      = 1'b1;
      @(negedge clock);
      start      = 1'b0;
   endtask

   task automatic name_prefix(input string tag);
`ifdef CMD_SAVER_LOADMOD_EN
      logic [7:0] nm [8] = '{8'h50, 8'h52, 8'h4F, 8'h47, 8'h20, 8'h20, 8'h20, 8'h20};
      expect_byte({tag, "_n_type"}, 8'h05);
      expect_byte({tag, "_n_len"}, 8'h08);
      for (int i = 0; i < 8; i++) expect_byte({tag, "_n_byte"}, nm[i]);
`else
      tests = tests + 0;
`endif
   endtask

   task automatic check_done(input string tag, input int dn0);
      check({tag, "_done_pulse"}, 32'(done), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_wait_end"}, 32'(ioctl_wait), 32'd1);
      @(negedge clock);
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_done_count"}, 32'(done_cnt - dn0), 32'd1);
   endtask

   task automatic run_stream(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x,
                             input int exp_size, input string tag);
      int n, total, blk, rd0, dn0;
      logic [15:0] a;
      n     = (e >= s) ? (int'(e) - int'(s) + 1) : 0;
      total = n;
      rd0   = rd_cnt;
      dn0   = done_cnt;
      a     = s;
      do_start(s, e, x);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_file_size"}, 32'(file_size), 32'(exp_size + NAME_EXTRA));
      name_prefix(tag);
      while (n > 0) begin
         blk = (n > 256) ? 256 : n;
         expect_byte({tag, "_d_type"}, 8'h01);
         expect_byte({tag, "_d_len"}, 8'(blk + 2));
         expect_byte({tag, "_d_lsb"}, a[7:0]);
         expect_byte({tag, "_d_msb"}, a[15:8]);
         for (int i = 0; i < blk; i++) begin
            expect_data({tag, "_data"}, ram_val(a));
            a = a + 16'd1;
         end
         n = n - blk;
      end
      expect_byte({tag, "_x_type"}, 8'h02);
      expect_byte({tag, "_x_len"}, 8'h02);
      expect_byte({tag, "_x_lsb"}, x[7:0]);
      expect_byte({tag, "_x_msb"}, x[15:8]);
      check_done(tag, dn0);
      check({tag, "_ram_reads"}, 32'(rd_cnt - rd0), 32'(total));
      $display("[TB] stream %s: range %h..%h, %0d data bytes", tag, s, e, total);
   endtask

   initial begin
      logic [7:0] b;
      int w, dn0, rd0;

      @(negedge clock);
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ram_rd", 32'(ram_rd), 32'd0);
      check("rst_din", 32'(ioctl_din), 32'd0);
      check("rst_file_size", 32'(file_size), 32'd0);
      reset_n      = 1'b1;
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd2;
      @(negedge clock);

      run_stream(16'h5200, 16'h5200, 16'h5200, 9, "one");
      run_stream(16'h6000, 16'h60FF, 16'h6012, 264, "blk256");
      run_stream(16'h6000, 16'h6100, 16'h6100, 269, "blk257");
      run_stream(16'h7000, 16'h6FFF, 16'h1234, 4, "empty");

      // Handshake robustness: reads during wait and with a foreign index must not consume.
      dn0 = done_cnt;
      do_start(16'h5200, 16'h5200, 16'h5200);
      check("hs_file_size", 32'(file_size), 32'(9 + NAME_EXTRA));
      name_prefix("hs");
      expect_byte("hs_d_type", 8'h01);
      expect_byte("hs_d_len", 8'h03);
      expect_byte("hs_d_lsb", 8'h00);
      expect_byte("hs_d_msb", 8'h52);
      ioctl_rd = 1'b1;
      @(negedge clock);
      @(negedge clock);
      ioctl_rd = 1'b0;
      check("hs_wait_held", 32'(ioctl_wait), 32'd1);
      w = 0;
      while (ioctl_wait !== 1'b0 && w < 50) begin
         @(negedge clock);
         w++;
      end
      ioctl_index = 8'd3;
      ioctl_rd    = 1'b1;
      @(negedge clock);
      @(negedge clock);
      ioctl_rd    = 1'b0;
      ioctl_index = 8'd2;
      check("hs_busy_kept", 32'(busy), 32'd1);
      check("hs_wait_kept", 32'(ioctl_wait), 32'd0);
      expect_byte("hs_data", 8'hAA);
      expect_byte("hs_x_type", 8'h02);
      expect_byte("hs_x_len", 8'h02);
      expect_byte("hs_x_lsb", 8'h00);
      expect_byte("hs_x_msb", 8'h52);
      check_done("hs", dn0);
      $display("[TB] stream hs: ignored reads during wait and on index 3");

      // Asynchronous reset while a data byte is being presented.
      dn0 = done_cnt;
      do_start(16'h6000, 16'h60FF, 16'h6000);
      name_prefix("rst");
      expect_byte("rst_d_type", 8'h01);
      expect_byte("rst_d_len", 8'h02);
      expect_byte("rst_d_lsb", 8'h00);
      expect_byte("rst_d_msb", 8'h60);
      w = 0;
      while (ioctl_wait !== 1'b0 && w < 50) begin
         @(negedge clock);
         w++;
      end
      check("rst_mid_in_data", 32'(ioctl_wait), 32'd0);
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_wait", 32'(ioctl_wait), 32'd1);
      check("rst_mid_ram_rd", 32'(ram_rd), 32'd0);
      rd0 = rd_cnt;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_mid_no_reads", 32'(rd_cnt - rd0), 32'd0);
      check("rst_mid_no_done", 32'(done_cnt - dn0), 32'd0);
      $display("[TB] stream rst: reset asserted mid data byte");
      run_stream(16'h5200, 16'h5200, 16'h5200, 9, "after_rst");

      // Full 64K range: size only, first bytes, then the host abandons the upload.
      dn0 = done_cnt;
      rd0 = rd_cnt;
      do_start(16'h0000, 16'hFFFF, 16'h0000);
      check("full_file_size", 32'(file_size), 32'(66564 + NAME_EXTRA));
      name_prefix("full");
      expect_byte("full_d_type", 8'h01);
      expect_byte("full_d_len", 8'h02);
      expect_byte("full_d_lsb", 8'h00);
      expect_byte("full_d_msb", 8'h00);
      expect_data("full_data0", ram_val(16'h0000));
      expect_data("full_data1", ram_val(16'h0001));
      ioctl_upload = 1'b0;
      @(negedge clock);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wait", 32'(ioctl_wait), 32'd1);
      for (int i = 0; i < 6; i++) @(negedge clock);
      check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
      check("abort_reads", 32'(rd_cnt - rd0), 32'd3);
      ioctl_upload = 1'b1;
      @(negedge clock);
      $display("[TB] stream full: 64K range aborted after two data bytes");

      check("no_idle_reads", 32'(rd_idle), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
